// File: rtl/regfile_writeback_queue.sv
// regfile_writeback_queue
//   Buffers results from the ALU path (src0) and the load/memory path (src1)
//   in a small in-order FIFO. The FIFO drains one entry per cycle into the
//   register file's single write port. Decode can look up values that are
//   still queued through two forwarding ports.
//
// Ports
//   clk, reset                : clock; synchronous active-high reset
//   src0_valid/rd/data/ready  : ALU result input
//   src1_valid/rd/data/ready  : memory result input
//   drain_en                  : write port available (low holds the queue)
//   RegWrite, RD, WriteData   : register-file write port (combinational from head)
//   fwd_rs1/2                 : decode lookup addresses
//   fwd_hit1/2, fwd_data1/2   : youngest queued value for each lookup
//   count                     : current occupancy
//
// Handshake: a source transfers on a rising edge where valid && ready are both
// high. Ready depends only on the registered occupancy (and, for src1, on
// src0_valid), so a same-cycle drain never creates space. An accepted result
// whose rd is 0 is consumed but not stored.
module regfile_writeback_queue #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       src0_valid,
  input  logic [4:0]                 src0_rd,
  input  logic [XLEN-1:0]            src0_data,
  output logic                       src0_ready,
  input  logic                       src1_valid,
  input  logic [4:0]                 src1_rd,
  input  logic [XLEN-1:0]            src1_data,
  output logic                       src1_ready,
  input  logic                       drain_en,
  output logic                       RegWrite,
  output logic [4:0]                 RD,
  output logic [XLEN-1:0]            WriteData,
  input  logic [4:0]                 fwd_rs1,
  input  logic [4:0]                 fwd_rs2,
  output logic                       fwd_hit1,
  output logic [XLEN-1:0]            fwd_data1,
  output logic                       fwd_hit2,
  output logic [XLEN-1:0]            fwd_data2,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL     = CW'(DEPTH);
  localparam logic [CW-1:0] FULL_M1  = CW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_M2  = CW'(DEPTH - 2);

  logic [AW-1:0]   head;
  logic [AW-1:0]   tail;
  logic [CW-1:0]   count_r;
  logic            ent_v    [DEPTH];
  logic [4:0]      ent_rd   [DEPTH];
  logic [XLEN-1:0] ent_data [DEPTH];

  logic            store0;
  logic            store1;
  logic [1:0]      n_st;
  logic [AW-1:0]   tail1;
  logic            deq;

  assign count = count_r;

  // src1 may only take the last slot when src0 is not competing for it.
  assign src0_ready = (count_r < FULL);
  assign src1_ready = (count_r <= FULL_M2) || ((count_r == FULL_M1) && !src0_valid);

  assign store0 = src0_valid && src0_ready && (src0_rd != 5'd0);
  assign store1 = src1_valid && src1_ready && (src1_rd != 5'd0);
  assign n_st   = {1'b0, store0} + {1'b0, store1};
  // src1 lands behind src0 when both are stored in the same cycle.
  assign tail1  = store0 ? tail + AW'(1) : tail;

  assign deq       = drain_en && (count_r != '0);
  assign RegWrite  = deq;
  assign RD        = (count_r != '0) ? ent_rd[head]   : 5'd0;
  assign WriteData = (count_r != '0) ? ent_data[head] : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      head    <= '0;
      tail    <= '0;
      count_r <= '0;
      for (int i = 0; i < DEPTH; i++) ent_v[i] <= 1'b0;
    end else begin
      if (deq) begin
        ent_v[head] <= 1'b0;
        head        <= head + AW'(1);
      end
      if (store0) ent_v[tail]  <= 1'b1;
      if (store1) ent_v[tail1] <= 1'b1;
      tail    <= tail + AW'(n_st);
      count_r <= count_r + CW'(n_st) - CW'(deq);
    end
  end

  // Payload storage needs no reset; the valid bits and count gate its use.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (store0) begin
        ent_rd[tail]   <= src0_rd;
        ent_data[tail] <= src0_data;
      end
      if (store1) begin
        ent_rd[tail1]   <= src1_rd;
        ent_data[tail1] <= src1_data;
      end
    end
  end

  // Walk entries oldest to youngest so a later match overrides an earlier
  // one; the head stays visible during its drain cycle.
  logic [AW-1:0] idx;
  always_comb begin
    fwd_hit1  = 1'b0;
    fwd_data1 = '0;
    fwd_hit2  = 1'b0;
    fwd_data2 = '0;
    idx       = head;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + AW'(i);
      if (ent_v[idx] && (fwd_rs1 != 5'd0) && (ent_rd[idx] == fwd_rs1)) begin
        fwd_hit1  = 1'b1;
        fwd_data1 = ent_data[idx];
      end
      if (ent_v[idx] && (fwd_rs2 != 5'd0) && (ent_rd[idx] == fwd_rs2)) begin
        fwd_hit2  = 1'b1;
        fwd_data2 = ent_data[idx];
      end
    end
  end

endmodule
